gol_seq: RTL

GOL_SEQ -- requirements
Module: gol_seq

---
 rtl/gol_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gol_seq.sv
`timescale 1ns/1ps
// gol_seq: sequencer for an 8x8 Game-of-Life engine.
// It holds the current generation and advances it from an external
// combinational next-state datapath, every TICK_DIV clocks while running.
// It also detects extinction, still life and a generation limit.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cmd_valid    command request
//   cmd_ready    command accept (always 1)
//   cmd_op       0=LOAD 1=RUN 2=STEP 3=HALT
//   cmd_data     seed grid for LOAD
//   cmd_count    generation limit for RUN (0 = unlimited)
//   cur_grid     current grid; cell(r,c) = bit 63-(8r+c)
//   nxt_grid     next generation of cur_grid from the external datapath
//   gen_count    generations advanced since the last LOAD (saturating)
//   busy         high while running
//   done         sticky completion flag
//   status       0=NONE 1=STABLE 2=EXTINCT 3=LIMIT
//   grid_valid   one-cycle pulse after each committed advance
module gol_seq #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_data,
    input  logic [15:0] cmd_count,
    output logic [63:0] cur_grid,
    input  logic [63:0] nxt_grid,
    output logic [15:0] gen_count,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic        grid_valid
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_STABLE  = 2'd1;
    localparam logic [1:0] ST_EXTINCT = 2'd2;
    localparam logic [1:0] ST_LIMIT   = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [63:0] grid_q,  grid_d;
    logic [15:0] gen_q,   gen_d;
    logic [15:0] rem_q,   rem_d;
    logic [15:0] div_q,   div_d;
    logic        done_q,  done_d;
    logic [1:0]  status_q, status_d;
    logic        gvld_q,  gvld_d;

    logic        accept;
    logic        term;
    logic [1:0]  term_status;

    assign cmd_ready  = 1'b1;
    assign accept     = cmd_valid;
    assign busy       = (state_q == S_RUN);
    assign cur_grid   = grid_q;
    assign gen_count  = gen_q;
    assign done       = done_q;
    assign status     = status_q;
    assign grid_valid = gvld_q;

    // Termination in priority order; only acted upon on an advance edge.
    always_comb begin
        term        = 1'b1;
        term_status = ST_NONE;
        if (nxt_grid == 64'd0) begin
            term_status = ST_EXTINCT;
        end else if (nxt_grid == grid_q) begin
            term_status = ST_STABLE;
        end else if (rem_q == 16'd1) begin
            term_status = ST_LIMIT;
        end else begin
            term = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        rem_d    = rem_q;
        div_d    = div_q;
        done_d   = done_q;
        status_d = status_q;
        gvld_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            grid_d   = cmd_data;
                            gen_d    = 16'd0;
                            status_d = ST_NONE;
                            done_d   = 1'b0;
                        end
                        OP_RUN, OP_STEP: begin
                            state_d  = S_RUN;
                            rem_d    = (cmd_op == OP_RUN) ? cmd_count : 16'd1;
                            done_d   = 1'b0;
                            status_d = ST_NONE;
                            div_d    = 16'd0;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // HALT beats a coincident advance; other commands are dropped.
                if (accept && cmd_op == OP_HALT) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b0;
                    status_d = ST_NONE;
                end else if (div_q == DIV_LAST) begin
                    div_d  = 16'd0;
                    grid_d = nxt_grid;
                    gen_d  = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
                    gvld_d = 1'b1;
                    if (term) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        status_d = term_status;
                    end else if (rem_q != 16'd0) begin
                        rem_d = rem_q - 16'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grid_q   <= 64'd0;
            gen_q    <= 16'd0;
            rem_q    <= 16'd0;
            div_q    <= 16'd0;
            done_q   <= 1'b0;
            status_q <= ST_NONE;
            gvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            done_q   <= done_d;
            status_q <= status_d;
            gvld_q   <= gvld_d;
        end
    end

endmodule
